// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with built-in test patterns.
// All outputs are registered and show the counter state of the previous cycle.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int HS_POL     = 0,
  parameter int VS_POL     = 0,
  parameter int COLOR_BITS = 4,
  parameter int CHECK_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  output logic [COLOR_BITS-1:0] r,
  output logic [COLOR_BITS-1:0] g,
  output logic [COLOR_BITS-1:0] b,
  output logic                  hs,
  output logic                  vs,
  output logic                  de,
  output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0] x,
  output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0] y,
  output logic                  frame_start,
  output logic [7:0]            frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW      = $clog2(H_TOTAL);
  localparam int YW      = $clog2(V_TOTAL);

  localparam logic [XW-1:0] H_LAST     = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT      = XW'(H_ACTIVE);
  localparam logic [XW-1:0] H_ACT_LAST = XW'(H_ACTIVE - 1);
  localparam logic [XW-1:0] HS_START   = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END     = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [XW-1:0] BAR_RELOAD = XW'(H_ACTIVE / 8 - 1);
  localparam logic [YW-1:0] V_LAST     = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT      = YW'(V_ACTIVE);
  localparam logic [YW-1:0] V_ACT_LAST = YW'(V_ACTIVE - 1);
  localparam logic [YW-1:0] VS_START   = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END     = YW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  localparam logic [1:0] MODE_BLACK  = 2'd0;
  localparam logic [1:0] MODE_BARS   = 2'd1;
  localparam logic [1:0] MODE_CHECK  = 2'd2;
  localparam logic [1:0] MODE_BORDER = 2'd3;

  if (H_ACTIVE < 8 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      COLOR_BITS < 1 || CHECK_LOG2 < 1 || CHECK_LOG2 > 30 ||
      HS_POL < 0 || HS_POL > 1 || VS_POL < 0 || VS_POL > 1) begin : g_param_check
    $fatal(1, "vga_timing_gen: illegal parameter set");
  end

  logic [XW-1:0] count_h;
  logic [YW-1:0] count_v;
  logic [XW-1:0] bar_left;
  logic [2:0]    bar_idx;
  logic [1:0]    mode_reg;
  logic [1:0]    mode_eff;
  logic [2:0]    rgb;
  logic          h_wrap;
  logic          v_wrap;
  logic          first_px;
  logic          visible;
  logic          check_odd;

  assign h_wrap    = (count_h == H_LAST);
  assign v_wrap    = (count_v == V_LAST);
  assign first_px  = (count_h == '0) && (count_v == '0);
  assign visible   = (count_h < H_ACT) && (count_v < V_ACT);
  assign check_odd = (((32'(count_h) ^ 32'(count_v)) >> CHECK_LOG2) & 32'd1) != 32'd0;

  // NOTE: pixel (0,0) takes mode straight from the port so the freshly
  // sampled value covers the whole frame, including its first pixel.
  assign mode_eff = first_px ? mode : mode_reg;

  function automatic logic [2:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return 3'b111;
      3'd1:    return 3'b110;
      3'd2:    return 3'b011;
      3'd3:    return 3'b010;
      3'd4:    return 3'b101;
      3'd5:    return 3'b100;
      3'd6:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  always_comb begin
    rgb = 3'b000;
    case (mode_eff)
      MODE_BARS:   rgb = bar_color(bar_idx);
      MODE_CHECK:  rgb = check_odd ? 3'b000 : 3'b111;
      MODE_BORDER: rgb = (count_h == '0 || count_h == H_ACT_LAST ||
                          count_v == '0 || count_v == V_ACT_LAST) ? 3'b111 : 3'b000;
      MODE_BLACK:  rgb = 3'b000;
      default:     rgb = 3'b000;
    endcase
    if (!visible) rgb = 3'b000;
  end

  // Raster counters; the bar index steps on a per-line down-counter instead of h / width.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_h     <= '0;
      count_v     <= '0;
      bar_idx     <= 3'd0;
      bar_left    <= BAR_RELOAD;
      mode_reg    <= MODE_BLACK;
      frame_count <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge state.
      mode_reg <= mode_eff;
      if (h_wrap) begin
        count_h  <= '0;
        bar_idx  <= 3'd0;
        bar_left <= BAR_RELOAD;
        count_v  <= v_wrap ? '0 : count_v + 1'b1;
        if (v_wrap) frame_count <= frame_count + 8'd1;
      end else begin
        count_h <= count_h + 1'b1;
        if (bar_left != '0) begin
          bar_left <= bar_left - 1'b1;
        end else if (bar_idx != 3'd7) begin
          bar_idx  <= bar_idx + 3'd1;
          bar_left <= BAR_RELOAD;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs          <= ~HS_ON;
      vs          <= ~VS_ON;
      de          <= 1'b0;
      r           <= '0;
      g           <= '0;
      b           <= '0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
    end else begin
      hs          <= (count_h >= HS_START && count_h < HS_END) ? HS_ON : ~HS_ON;
      vs          <= (count_v >= VS_START && count_v < VS_END) ? VS_ON : ~VS_ON;
      de          <= visible;
      r           <= {COLOR_BITS{rgb[2]}};
      g           <= {COLOR_BITS{rgb[1]}};
      b           <= {COLOR_BITS{rgb[0]}};
      x           <= count_h;
      y           <= count_v;
      frame_start <= first_px;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: four parameter sets on one clock, each compared
// cycle by cycle against an arithmetic raster model.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [3:0]  r, g, b;
    logic        hs, vs, de, fs;
    logic [15:0] x, y;
    logic [7:0]  fc;
  } obs_t;

  typedef struct {
    int hact, hfp, hsync, hbp, vact, vfp, vsync, vbp, hpol, vpol, cl;
  } cfg_t;

  localparam int ID_DEF = 0;
  localparam int ID_MED = 1;
  localparam int ID_POL = 2;
  localparam int ID_SML = 3;

  cfg_t cfgs [4] = '{
    '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 5},
    '{ 64,  4,  8,  4,  48,  2, 2,  4, 0, 0, 5},
    '{ 64,  4,  8,  4,  48,  2, 2,  4, 1, 1, 5},
    '{  8,  2,  2,  2,   4,  1, 1,  1, 0, 0, 5}
  };

  logic       clk  = 1'b0;
  logic       rst  = 1'b0;
  logic [1:0] mode = 2'd0;
  int         checks   = 0;
  int         failures = 0;
  int         k = 0;
  logic [1:0] frame_mode [4];
  obs_t       ob [4];

  always #5 clk = ~clk;

  logic [3:0] d_r, d_g, d_b, m_r, m_g, m_b, p_r, p_g, p_b, s_r, s_g, s_b;
  logic       d_hs, d_vs, d_de, d_fs, m_hs, m_vs, m_de, m_fs;
  logic       p_hs, p_vs, p_de, p_fs, s_hs, s_vs, s_de, s_fs;
  logic [9:0] d_x, d_y;
  logic [6:0] m_x, p_x;
  logic [5:0] m_y, p_y;
  logic [3:0] s_x;
  logic [2:0] s_y;
  logic [7:0] d_fc, m_fc, p_fc, s_fc;

  vga_timing_gen u_def (
    .clk(clk), .rst(rst), .mode(mode), .r(d_r), .g(d_g), .b(d_b), .hs(d_hs), .vs(d_vs),
    .de(d_de), .x(d_x), .y(d_y), .frame_start(d_fs), .frame_count(d_fc));

  vga_timing_gen #(.H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
                   .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(4)) u_med (
    .clk(clk), .rst(rst), .mode(mode), .r(m_r), .g(m_g), .b(m_b), .hs(m_hs), .vs(m_vs),
    .de(m_de), .x(m_x), .y(m_y), .frame_start(m_fs), .frame_count(m_fc));

  vga_timing_gen #(.H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
                   .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(4),
                   .HS_POL(1), .VS_POL(1)) u_pol (
    .clk(clk), .rst(rst), .mode(mode), .r(p_r), .g(p_g), .b(p_b), .hs(p_hs), .vs(p_vs),
    .de(p_de), .x(p_x), .y(p_y), .frame_start(p_fs), .frame_count(p_fc));

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)) u_sml (
    .clk(clk), .rst(rst), .mode(mode), .r(s_r), .g(s_g), .b(s_b), .hs(s_hs), .vs(s_vs),
    .de(s_de), .x(s_x), .y(s_y), .frame_start(s_fs), .frame_count(s_fc));

  always_comb begin
    ob[ID_DEF] = {d_r, d_g, d_b, d_hs, d_vs, d_de, d_fs, 16'(d_x), 16'(d_y), d_fc};
    ob[ID_MED] = {m_r, m_g, m_b, m_hs, m_vs, m_de, m_fs, 16'(m_x), 16'(m_y), m_fc};
    ob[ID_POL] = {p_r, p_g, p_b, p_hs, p_vs, p_de, p_fs, 16'(p_x), 16'(p_y), p_fc};
    ob[ID_SML] = {s_r, s_g, s_b, s_hs, s_vs, s_de, s_fs, 16'(s_x), 16'(s_y), s_fc};
  end

  function automatic int ht_of(cfg_t c);
    return c.hact + c.hfp + c.hsync + c.hbp;
  endfunction

  function automatic int ft_of(cfg_t c);
    return ht_of(c) * (c.vact + c.vfp + c.vsync + c.vbp);
  endfunction

  // Expected outputs after the kk-th rising edge since reset release (kk >= 1).
  function automatic obs_t model(cfg_t c, logic [1:0] md, int kk);
    obs_t       e;
    logic [2:0] bars [8];
    logic [2:0] rgb;
    int         p, h, v, bar;
    bars = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
    p    = (kk - 1) % ft_of(c);
    h    = p % ht_of(c);
    v    = p / ht_of(c);
    e.de = (h < c.hact) && (v < c.vact);
    e.hs = (h >= c.hact + c.hfp && h < c.hact + c.hfp + c.hsync) ? (c.hpol != 0) : (c.hpol == 0);
    e.vs = (v >= c.vact + c.vfp && v < c.vact + c.vfp + c.vsync) ? (c.vpol != 0) : (c.vpol == 0);
    rgb  = 3'b000;
    if (e.de) begin
      case (md)
        2'd1: begin
          bar = h / (c.hact / 8);
          if (bar > 7) bar = 7;
          rgb = bars[bar];
        end
        2'd2: rgb = (((h >> c.cl) ^ (v >> c.cl)) & 1) != 0 ? 3'd0 : 3'd7;
        2'd3: rgb = (h == 0 || h == c.hact - 1 || v == 0 || v == c.vact - 1) ? 3'd7 : 3'd0;
        default: rgb = 3'd0;
      endcase
    end
    e.r  = {4{rgb[2]}};
    e.g  = {4{rgb[1]}};
    e.b  = {4{rgb[0]}};
    e.fs = (p == 0);
    e.x  = 16'(h);
    e.y  = 16'(v);
    e.fc = 8'((kk / ft_of(c)) % 256);
    return e;
  endfunction

  function automatic obs_t reset_obs(cfg_t c);
    obs_t e;
    e    = '0;
    e.hs = (c.hpol == 0);
    e.vs = (c.vpol == 0);
    return e;
  endfunction

  // Edge counter and per-instance frame mode, sampled on each frame's first pixel.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      k <= 0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (k % ft_of(cfgs[i]) == 0) frame_mode[i] <= mode;
      k <= k + 1;
    end
  end

  task automatic restart(input logic [1:0] md, input int hold);
    rst  = 1'b0;
    mode = md;
    repeat (hold) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst  = 1'b0;
    mode = 2'd1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ob[i] !== reset_obs(cfgs[i])) begin
        failures++;
        $display("FAIL reset_state inst=%0d got=%h exp=%h", i, ob[i], reset_obs(cfgs[i]));
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_first_pixel();
    obs_t e;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      e = model(cfgs[i], frame_mode[i], k);
      checks++;
      if (ob[i] !== e) begin
        failures++;
        $display("FAIL first_pixel inst=%0d got=%h exp=%h", i, ob[i], e);
      end
    end
    checks++;
    if ({ob[ID_SML].de, ob[ID_SML].fs, ob[ID_SML].x, ob[ID_SML].y} !== {1'b1, 1'b1, 16'd0, 16'd0}) begin
      failures++;
      $display("FAIL first_pixel_flags got de=%b fs=%b x=%0d y=%0d exp 1 1 0 0",
               ob[ID_SML].de, ob[ID_SML].fs, ob[ID_SML].x, ob[ID_SML].y);
    end
  endtask

  // Continues from the first pixel; covers pixels 0..2399 of the default raster.
  task automatic test_default_lines();
    obs_t e;
    int   hs_low, de_high;
    hs_low  = (ob[ID_DEF].hs == 1'b0) ? 1 : 0;
    de_high = (ob[ID_DEF].de == 1'b1) ? 1 : 0;
    while (k < 2400) begin
      @(negedge clk);
      e = model(cfgs[ID_DEF], frame_mode[ID_DEF], k);
      checks++;
      if (ob[ID_DEF] !== e) begin
        failures++;
        $display("FAIL default_pixel k=%0d got=%h exp=%h", k, ob[ID_DEF], e);
      end
      if (ob[ID_DEF].hs == 1'b0) hs_low++;
      if (ob[ID_DEF].de == 1'b1) de_high++;
    end
    checks++;
    if (hs_low !== 3 * 96) begin
      failures++;
      $display("FAIL default_hs_low got=%0d exp=%0d", hs_low, 3 * 96);
    end
    checks++;
    if (de_high !== 3 * 640) begin
      failures++;
      $display("FAIL default_de_high got=%0d exp=%0d", de_high, 3 * 640);
    end
  endtask

  task automatic test_small_bars();
    obs_t        e;
    logic [23:0] line0;
    int          p;
    line0 = '0;
    restart(2'd1, 2);
    while (k < 2 * ft_of(cfgs[ID_SML])) begin
      @(negedge clk);
      p = k - 1;
      e = model(cfgs[ID_SML], frame_mode[ID_SML], k);
      checks++;
      if (ob[ID_SML] !== e) begin
        failures++;
        $display("FAIL small_pixel k=%0d got=%h exp=%h", k, ob[ID_SML], e);
      end
      if (p < 8) line0[(7 - p) * 3 +: 3] = {ob[ID_SML].r[3], ob[ID_SML].g[3], ob[ID_SML].b[3]};
    end
    checks++;
    if (line0 !== 24'b111_110_011_010_101_100_001_000) begin
      failures++;
      $display("FAIL small_bar_order got=%b exp=%b", line0, 24'b111_110_011_010_101_100_001_000);
    end
  endtask

  task automatic test_polarity();
    obs_t e;
    int   pol_vs_high, pol_hs_high, med_vs_low, first_hs;
    pol_vs_high = 0; pol_hs_high = 0; med_vs_low = 0; first_hs = -1;
    restart(2'd1, 3);
    while (k < ft_of(cfgs[ID_POL])) begin
      @(negedge clk);
      for (int i = ID_MED; i <= ID_POL; i++) begin
        e = model(cfgs[i], frame_mode[i], k);
        checks++;
        if (ob[i] !== e) begin
          failures++;
          $display("FAIL polarity_pixel inst=%0d k=%0d got=%h exp=%h", i, k, ob[i], e);
        end
      end
      if (ob[ID_POL].vs == 1'b1) pol_vs_high++;
      if (ob[ID_POL].hs == 1'b1) pol_hs_high++;
      if (ob[ID_MED].vs == 1'b0) med_vs_low++;
      if (ob[ID_POL].hs == 1'b1 && first_hs < 0) first_hs = k - 1;
    end
    checks++;
    if (pol_vs_high !== 2 * 80 || med_vs_low !== 2 * 80) begin
      failures++;
      $display("FAIL polarity_vs_width got pol=%0d med=%0d exp=%0d", pol_vs_high, med_vs_low, 160);
    end
    checks++;
    if (pol_hs_high !== 56 * 8 || first_hs !== 68) begin
      failures++;
      $display("FAIL polarity_hs got count=%0d first=%0d exp count=%0d first=68",
               pol_hs_high, first_hs, 56 * 8);
    end
  endtask

  task automatic test_mode_switch();
    obs_t e;
    int   p;
    restart(2'd1, 2);
    while (k < 2 * ft_of(cfgs[ID_MED])) begin
      @(negedge clk);
      p = k - 1;
      e = model(cfgs[ID_MED], frame_mode[ID_MED], k);
      checks++;
      if (ob[ID_MED] !== e) begin
        failures++;
        $display("FAIL switch_pixel k=%0d got=%h exp=%h", k, ob[ID_MED], e);
      end
      if (p == 30 * 80 + 8) begin
        checks++;
        if ({ob[ID_MED].r, ob[ID_MED].g, ob[ID_MED].b} !== 12'hFF0) begin
          failures++;
          $display("FAIL switch_frame0_bar got=%h exp=ff0",
                   {ob[ID_MED].r, ob[ID_MED].g, ob[ID_MED].b});
        end
      end
      if (p == 4480 + 32) begin
        checks++;
        if (ob[ID_MED].r !== 4'h0) begin
          failures++;
          $display("FAIL switch_check_32_0 got=%h exp=0", ob[ID_MED].r);
        end
      end
      if (p == 4480 + 32 * 80 + 32) begin
        checks++;
        if (ob[ID_MED].r !== 4'hF) begin
          failures++;
          $display("FAIL switch_check_32_32 got=%h exp=f", ob[ID_MED].r);
        end
      end
      if (p == 20 * 80 + 10) mode = 2'd2;
    end
  endtask

  task automatic test_reset_midframe();
    obs_t e;
    restart(2'($urandom_range(1, 3)), 2);
    while (k < 2 * 800 + 700) begin
      @(negedge clk);
      e = model(cfgs[ID_DEF], frame_mode[ID_DEF], k);
      checks++;
      if (ob[ID_DEF] !== e) begin
        failures++;
        $display("FAIL midframe_pixel k=%0d got=%h exp=%h", k, ob[ID_DEF], e);
      end
    end
    rst = 1'b0;
    #1;
    for (int i = ID_DEF; i <= ID_SML; i += ID_SML) begin
      checks++;
      if (ob[i] !== reset_obs(cfgs[i])) begin
        failures++;
        $display("FAIL midframe_async inst=%0d got=%h exp=%h", i, ob[i], reset_obs(cfgs[i]));
      end
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (ob[ID_DEF] !== reset_obs(cfgs[ID_DEF])) begin
        failures++;
        $display("FAIL midframe_hold got=%h exp=%h", ob[ID_DEF], reset_obs(cfgs[ID_DEF]));
      end
    end
    rst = 1'b1;
    @(negedge clk);
    e = model(cfgs[ID_DEF], frame_mode[ID_DEF], k);
    checks++;
    if (ob[ID_DEF] !== e || ob[ID_DEF].fs !== 1'b1) begin
      failures++;
      $display("FAIL midframe_restart got=%h exp=%h", ob[ID_DEF], e);
    end
  endtask

  task automatic test_frame_wrap();
    obs_t       e;
    int         fs_cnt;
    logic       seen_wrap;
    logic [7:0] prev_fc;
    fs_cnt = 0; seen_wrap = 1'b0; prev_fc = 8'd0;
    restart(2'($urandom_range(0, 3)), 2);
    while (k < 256 * ft_of(cfgs[ID_SML])) begin
      @(negedge clk);
      e = model(cfgs[ID_SML], frame_mode[ID_SML], k);
      checks++;
      if (ob[ID_SML] !== e) begin
        failures++;
        $display("FAIL wrap_pixel k=%0d got=%h exp=%h", k, ob[ID_SML], e);
      end
      if (ob[ID_SML].fs == 1'b1) fs_cnt++;
      if (prev_fc == 8'd255 && ob[ID_SML].fc == 8'd0) seen_wrap = 1'b1;
      prev_fc = ob[ID_SML].fc;
      if ($urandom_range(0, 40) == 0) mode = 2'($urandom_range(0, 3));
    end
    checks++;
    if (fs_cnt !== 256) begin
      failures++;
      $display("FAIL wrap_frame_start_count got=%0d exp=256", fs_cnt);
    end
    checks++;
    if (seen_wrap !== 1'b1 || ob[ID_SML].fc !== 8'd0) begin
      failures++;
      $display("FAIL wrap_frame_count got wrap=%b fc=%0d exp wrap=1 fc=0", seen_wrap, ob[ID_SML].fc);
    end
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_default_lines();
    test_small_bars();
    test_polarity();
    test_mode_switch();
    test_reset_midframe();
    test_frame_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
